// File: rtl/video_timing_meter.sv
// Raster meter: measures line and frame geometry from pixel-enable, blank and sync
// inputs, publishes once per frame on the vsync falling edge, and tracks lock.
module video_timing_meter #(
  parameter int TIMEOUT     = 1023,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic       hb,
  input  logic       vb,
  input  logic       hs,
  input  logic       vs,
  output logic [9:0] h_total,
  output logic [9:0] h_active,
  output logic [9:0] hs_width,
  output logic [8:0] v_total,
  output logic [8:0] v_active,
  output logic [8:0] vs_width,
  output logic       frame_stb,
  output logic       locked,
  output logic       no_signal
);

  typedef enum logic [1:0] {NOSIG, SYNC, MEASURE} state_t;
  state_t state_reg, state_next;

  logic       prev_hs_reg, prev_vs_reg;
  logic [9:0] pix_cnt_reg, act_cnt_reg, hsw_cnt_reg;
  logic [9:0] line_h_total_reg, line_h_active_reg, line_hs_width_reg;
  logic [8:0] v_cnt_reg, v_act_cnt_reg, vsw_cnt_reg;
  logic [3:0] stable_cnt_reg, stable_cnt_next;

  logic       hs_fall, vs_fall, act_pix, line_has_act;
  logic       lost, publish, frame_clear, tuple_eq;
  logic [9:0] pix_cnt_next;
  logic [8:0] v_cnt_next;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  assign hs_fall      = ce_pix & prev_hs_reg & ~hs;
  assign vs_fall      = ce_pix & prev_vs_reg & ~vs;
  assign act_pix      = ~hb & ~vb;
  assign line_has_act = (act_cnt_reg != 10'd0);
  assign pix_cnt_next = hs_fall ? 10'd1 : sat_inc10(pix_cnt_reg);
  assign v_cnt_next   = hs_fall ? sat_inc9(v_cnt_reg) : v_cnt_reg;

  assign tuple_eq = ({line_h_total_reg, line_h_active_reg, line_hs_width_reg,
                      v_cnt_reg, v_act_cnt_reg, vsw_cnt_reg} ==
                     {h_total, h_active, hs_width, v_total, v_active, vs_width});
  assign stable_cnt_next = !tuple_eq ? 4'd1 :
                           (stable_cnt_reg == 4'hF) ? 4'hF : stable_cnt_reg + 4'd1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_reg <= NOSIG;
    else          state_reg <= state_next;
  end

  // Loss of signal outranks a coincident vsync: nothing is published on that pixel.
  always_comb begin
    state_next  = state_reg;
    lost        = 1'b0;
    publish     = 1'b0;
    frame_clear = 1'b0;
    if (ce_pix) begin
      case (state_reg)
        NOSIG: begin
          if (hs_fall) state_next = SYNC;
        end
        SYNC, MEASURE: begin
          if (int'(pix_cnt_next) >= TIMEOUT || v_cnt_next == 9'h1FF) begin
            lost       = 1'b1;
            state_next = NOSIG;
          end else if (vs_fall) begin
            frame_clear = 1'b1;
            publish     = (state_reg == MEASURE);
            state_next  = MEASURE;
          end
        end
        default: state_next = NOSIG;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_hs_reg       <= 1'b1;
      prev_vs_reg       <= 1'b1;
      pix_cnt_reg       <= 10'd0;
      act_cnt_reg       <= 10'd0;
      hsw_cnt_reg       <= 10'd0;
      line_h_total_reg  <= 10'd0;
      line_h_active_reg <= 10'd0;
      line_hs_width_reg <= 10'd0;
      v_cnt_reg         <= 9'd0;
      v_act_cnt_reg     <= 9'd0;
      vsw_cnt_reg       <= 9'd0;
      h_total           <= 10'd0;
      h_active          <= 10'd0;
      hs_width          <= 10'd0;
      v_total           <= 9'd0;
      v_active          <= 9'd0;
      vs_width          <= 9'd0;
    end else if (ce_pix) begin
      prev_hs_reg <= hs;
      prev_vs_reg <= vs;
      pix_cnt_reg <= pix_cnt_next;
      if (hs_fall) begin
        line_h_total_reg  <= pix_cnt_reg;
        line_hs_width_reg <= hsw_cnt_reg;
        if (line_has_act) line_h_active_reg <= act_cnt_reg;
        act_cnt_reg <= {9'd0, act_pix};
        hsw_cnt_reg <= 10'd1;
      end else begin
        if (act_pix) act_cnt_reg <= sat_inc10(act_cnt_reg);
        if (!hs)     hsw_cnt_reg <= sat_inc10(hsw_cnt_reg);
      end

      // A line closed on the vsync pixel belongs to the frame that is starting.
      if (state_reg == NOSIG) begin
        v_cnt_reg     <= 9'd0;
        v_act_cnt_reg <= 9'd0;
        vsw_cnt_reg   <= 9'd0;
      end else if (frame_clear) begin
        v_cnt_reg     <= {8'd0, hs_fall};
        v_act_cnt_reg <= {8'd0, hs_fall & line_has_act};
        vsw_cnt_reg   <= {8'd0, hs_fall & ~vs};
      end else if (hs_fall) begin
        v_cnt_reg <= v_cnt_next;
        if (line_has_act) v_act_cnt_reg <= sat_inc9(v_act_cnt_reg);
        if (!vs)          vsw_cnt_reg   <= sat_inc9(vsw_cnt_reg);
      end

      if (publish) begin
        h_total  <= line_h_total_reg;
        h_active <= line_h_active_reg;
        hs_width <= line_hs_width_reg;
        v_total  <= v_cnt_reg;
        v_active <= v_act_cnt_reg;
        vs_width <= vsw_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_stb      <= 1'b0;
      locked         <= 1'b0;
      no_signal      <= 1'b1;
      stable_cnt_reg <= 4'd0;
    end else begin
      frame_stb <= publish;
      no_signal <= (state_next == NOSIG);
      if (lost) begin
        stable_cnt_reg <= 4'd0;
        locked         <= 1'b0;
      end else if (publish) begin
        stable_cnt_reg <= stable_cnt_next;
        locked         <= (int'(stable_cnt_next) >= LOCK_FRAMES);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_meter.sv
// Bench for video_timing_meter: drives a reduced raster (318-pixel lines, 10-line
// frames) and checks every published frame against hand-computed expectations.
`timescale 1ns/1ps
module tb_video_timing_meter;

  localparam int HLEN     = 318;
  localparam int HB_HI    = 255;
  localparam int HS_LO    = 284;
  localparam int HS_HI    = 303;
  localparam int VB_LINES = 6;
  localparam int VS_LINE  = 6;
  localparam int VS_LINES = 3;
  localparam int EXP_HT   = 318;
  localparam int EXP_HSW  = 20;
  localparam int EXP_VA   = 6;
  localparam int EXP_VSW  = 3;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_pix  = 1'b0;
  logic       hb = 1'b1, vb = 1'b1, hs = 1'b1, vs = 1'b1;
  logic [9:0] h_total, h_active, hs_width;
  logic [8:0] v_total, v_active, vs_width;
  logic       frame_stb, locked, no_signal;

  typedef struct {
    int ht; int ha; int hsw; int vt; int va; int vsw; int lk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  video_timing_meter #(.TIMEOUT(1023), .LOCK_FRAMES(2)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .hb        (hb),
    .vb        (vb),
    .hs        (hs),
    .vs        (vs),
    .h_total   (h_total),
    .h_active  (h_active),
    .hs_width  (hs_width),
    .v_total   (v_total),
    .v_active  (v_active),
    .vs_width  (vs_width),
    .frame_stb (frame_stb),
    .locked    (locked),
    .no_signal (no_signal)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_h_total"},   int'(h_total),   0);
    check({tag, "_h_active"},  int'(h_active),  0);
    check({tag, "_hs_width"},  int'(hs_width),  0);
    check({tag, "_v_total"},   int'(v_total),   0);
    check({tag, "_v_active"},  int'(v_active),  0);
    check({tag, "_vs_width"},  int'(vs_width),  0);
    check({tag, "_frame_stb"}, int'(frame_stb), 0);
    check({tag, "_locked"},    int'(locked),    0);
    check({tag, "_no_signal"}, int'(no_signal), 1);
  endtask

  task automatic drive_pix(input logic h, input logic v, input logic hbl, input logic vbl);
    ce_pix = 1'b1; hs = h; vs = v; hb = hbl; vb = vbl;
    @(posedge clk_sys); #1;
  endtask

  // Idle cycle with scrambled inputs: the meter must ignore everything but ce_pix.
  task automatic gap();
    ce_pix = 1'b0; hs = ~hs; vs = ~vs; hb = ~hb; vb = ~vb;
    @(posedge clk_sys); #1;
  endtask

  task automatic run_frame(input int n_lines, input int hb_lo, input int vs_x,
                           input bit pub, input int exp_vt, input int exp_ha,
                           input int exp_lk, input bit chk_sync);
    for (int ln = 0; ln < n_lines; ln++) begin
      for (int x = 0; x < HLEN; x++) begin
        int   pos;
        logic v_lo;
        exp_t e;
        pos  = ln * HLEN + x;
        v_lo = (pos >= VS_LINE * HLEN + vs_x) && (pos < (VS_LINE + VS_LINES) * HLEN + vs_x);
        if (pub && ln == VS_LINE && x == vs_x) begin
          e.ht = EXP_HT; e.ha = exp_ha; e.hsw = EXP_HSW;
          e.vt = exp_vt; e.va = EXP_VA; e.vsw = EXP_VSW; e.lk = exp_lk;
          exp_q.push_back(e);
        end
        drive_pix(!(x >= HS_LO && x <= HS_HI), !v_lo,
                  !(x >= hb_lo && x <= HB_HI), !(ln < VB_LINES));
        if (chk_sync && ln == 0 && x == HS_LO - 1) check("nosig_before_hs", int'(no_signal), 1);
        if (chk_sync && ln == 0 && x == HS_LO)     check("nosig_cleared", int'(no_signal), 0);
        if ((x % 32) == 0) gap();
      end
    end
  endtask

  task automatic monitor();
    logic prev_stb;
    exp_t e;
    int   n;
    prev_stb = 1'b0;
    n = 0;
    forever begin
      @(negedge clk_sys);
      if (frame_stb) begin
        check("stb_one_cycle", int'(prev_stb), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_stb", int'(frame_stb), 0);
        end else begin
          e = exp_q.pop_front();
          n++;
          $display("publish %0d: h_total=%0d h_active=%0d hs_width=%0d v_total=%0d v_active=%0d vs_width=%0d locked=%0d",
                   n, h_total, h_active, hs_width, v_total, v_active, vs_width, locked);
          check("h_total",   int'(h_total),   e.ht);
          check("h_active",  int'(h_active),  e.ha);
          check("hs_width",  int'(hs_width),  e.hsw);
          check("v_total",   int'(v_total),   e.vt);
          check("v_active",  int'(v_active),  e.va);
          check("vs_width",  int'(vs_width),  e.vsw);
          check("locked",    int'(locked),    e.lk);
          check("no_signal", int'(no_signal), 0);
        end
      end
      prev_stb = frame_stb;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_values("por");
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    check("nosig_after_release", int'(no_signal), 1);

    // args: lines, hb_lo, vs_x, publish, exp v_total, exp h_active, exp locked, check sync exit
    run_frame(10, 1, 0,   0, 0,  0,   0, 1);  // hs_fall -> SYNC, vs_fall -> MEASURE
    run_frame(10, 1, 0,   1, 10, 255, 0, 0);  // first publish
    run_frame(10, 1, 0,   1, 10, 255, 1, 0);  // lock at second publish
    run_frame(10, 1, 0,   1, 10, 255, 1, 0);
    run_frame(10, 6, 0,   1, 10, 250, 0, 0);  // column fix changes the tuple
    run_frame(10, 6, 0,   1, 10, 250, 1, 0);
    run_frame(11, 6, 0,   1, 10, 250, 1, 0);  // long frame, reported on next publish
    run_frame(10, 6, 0,   1, 11, 250, 0, 0);
    run_frame(10, 6, 0,   1, 10, 250, 0, 0);
    run_frame(10, 6, 0,   1, 10, 250, 1, 0);
    run_frame(10, 6, 284, 1, 10, 250, 1, 0);  // hs_fall and vs_fall on the same pixel
    run_frame(10, 6, 284, 1, 10, 250, 1, 0);
    check("nosig_while_running", int'(no_signal), 0);

    for (int i = 0; i < 1100; i++) drive_pix(1'b1, 1'b1, 1'b1, 1'b1);
    check("timeout_no_signal", int'(no_signal), 1);
    check("timeout_locked",    int'(locked),    0);
    check("hold_h_total",      int'(h_total),   318);
    check("hold_h_active",     int'(h_active),  250);
    check("hold_v_total",      int'(v_total),   10);

    run_frame(10, 6, 0, 0, 0,  0,   0, 1);
    run_frame(10, 6, 0, 1, 10, 250, 0, 0);
    run_frame(10, 6, 0, 1, 10, 250, 1, 0);
    run_frame(4,  6, 0, 0, 0,  0,   0, 0);  // partial frame, then reset
    check("locked_before_reset", int'(locked), 1);
    #1 reset_n = 1'b0;
    ce_pix = 1'b0;
    #1;
    check_reset_values("async");
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;

    run_frame(10, 6, 0, 0, 0,  0,   0, 1);
    run_frame(10, 6, 0, 1, 10, 250, 0, 0);
    ce_pix = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    check("missing_stb", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
